y86_execute: RTL and testbench



---
 rtl/y86_execute.sv | 127 ++++++++++++
 tb/tb_y86_execute.sv | 134 +++++++++++++
 2 files changed

// File: rtl/y86_execute.sv
// Y86-64 execute stage: operand-select ALU, {ZF,SF,OF} condition-code register, Cnd evaluation.
// Defining EXEC_CC_OUT_EN adds the cc_o debug port carrying the registered CC.
module y86_execute (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  icode_i,
  input  logic [3:0]  ifunc_i,
  input  logic [63:0] valC_i,
  input  logic [63:0] valA_i,
  input  logic [63:0] valB_i,
  output logic [63:0] valE_o,
  output logic        Cnd_o
`ifdef EXEC_CC_OUT_EN
  ,
  output logic [2:0]  cc_o
`endif
);

  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_AND = 4'h2;
  localparam logic [3:0] F_XOR = 4'h3;

  logic [63:0] alu_a, alu_b;
  logic [63:0] sum, diff, alu_res;
  logic        alu_of;
  logic        cc_upd;
  logic [2:0]  cc_d, cc_q;
  logic        zf, sf, of;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (icode_i)
      I_RRMOVQ: alu_a = valA_i;
      I_IRMOVQ: alu_a = valC_i;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = valC_i;
        alu_b = valB_i;
      end
      I_OPQ: begin
        alu_a = valA_i;
        alu_b = valB_i;
      end
      I_CALL, I_PUSHQ: begin
        alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
        alu_b = valB_i;
      end
      I_RET, I_POPQ: begin
        alu_a = 64'd8;
        alu_b = valB_i;
      end
      default: ;
    endcase
  end

  // Non-OPq instructions always add; only OPq decodes ifunc, and bad OPq functions yield zero.
  always_comb begin
    sum     = alu_b + alu_a;
    diff    = alu_b - alu_a;
    alu_res = sum;
    alu_of  = 1'b0;
    if (icode_i == I_OPQ) begin
      case (ifunc_i)
        F_ADD: begin
          alu_res = sum;
          alu_of  = (alu_a[63] == alu_b[63]) && (sum[63] != alu_a[63]);
        end
        F_SUB: begin
          alu_res = diff;
          alu_of  = (alu_a[63] != alu_b[63]) && (diff[63] != alu_b[63]);
        end
        F_AND:   alu_res = alu_a & alu_b;
        F_XOR:   alu_res = alu_a ^ alu_b;
        default: alu_res = '0;
      endcase
    end
  end

  assign valE_o = alu_res;
  assign cc_upd = (icode_i == I_OPQ) && (ifunc_i <= F_XOR);
  assign cc_d   = {(alu_res == '0), alu_res[63], alu_of};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cc_q <= 3'b100;
    end else if (cc_upd) begin
      cc_q <= cc_d;
    end
  end

  assign zf = cc_q[2];
  assign sf = cc_q[1];
  assign of = cc_q[0];

  always_comb begin
    Cnd_o = 1'b0;
    if ((icode_i == I_RRMOVQ) || (icode_i == I_JXX)) begin
      case (ifunc_i)
        4'h0:    Cnd_o = 1'b1;
        4'h1:    Cnd_o = (sf ^ of) | zf;
        4'h2:    Cnd_o = sf ^ of;
        4'h3:    Cnd_o = zf;
        4'h4:    Cnd_o = ~zf;
        4'h5:    Cnd_o = ~(sf ^ of);
        4'h6:    Cnd_o = ~(sf ^ of) & ~zf;
        default: Cnd_o = 1'b0;
      endcase
    end
  end

`ifdef EXEC_CC_OUT_EN
  assign cc_o = cc_q;
`endif

endmodule

// File: tb/tb_y86_execute.sv
// Directed self-checking bench for y86_execute; checks cc_o directly when EXEC_CC_OUT_EN is defined.
module tb_y86_execute;

  logic        clk;
  logic        rst;
  logic [3:0]  icode;
  logic [3:0]  ifunc;
  logic [63:0] valC, valA, valB;
  logic [63:0] valE;
  logic        cnd;
`ifdef EXEC_CC_OUT_EN
  logic [2:0]  cc;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  y86_execute dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .icode_i (icode),
    .ifunc_i (ifunc),
    .valC_i  (valC),
    .valA_i  (valA),
    .valB_i  (valB),
    .valE_o  (valE),
    .Cnd_o   (cnd)
`ifdef EXEC_CC_OUT_EN
    ,
    .cc_o    (cc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction between edges, check the combinational outputs, then let it clock.
  task automatic exec(input string tag, input logic r, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] exp_e, input logic exp_cnd);
    @(negedge clk);
    rst = r; icode = ic; ifunc = fn; valC = c; valA = a; valB = b;
    #1;
    check_val({tag, "_valE"}, valE, exp_e);
    check_val({tag, "_cnd"}, {63'b0, cnd}, {63'b0, exp_cnd});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Sweep every jXX condition against the expected {ZF,SF,OF}; jXX never writes CC.
  task automatic probe_cc(input string tag, input logic [2:0] exp_cc);
    logic zf, sf, of, e;
    zf = exp_cc[2]; sf = exp_cc[1]; of = exp_cc[0];
    rst = 1'b0; icode = 4'h7; valA = 64'd11; valB = 64'd22; valC = 64'd33;
`ifdef EXEC_CC_OUT_EN
    check_val({tag, "_cc"}, {61'b0, cc}, {61'b0, exp_cc});
`endif
    for (int k = 0; k < 8; k++) begin
      ifunc = 4'(k);
      #1;
      case (k)
        0: e = 1'b1;
        1: e = (sf != of) || zf;
        2: e = (sf != of);
        3: e = zf;
        4: e = !zf;
        5: e = (sf == of);
        6: e = (sf == of) && !zf;
        default: e = 1'b0;
      endcase
      check_val($sformatf("%s_j%0d", tag, k), {63'b0, cnd}, {63'b0, e});
      if (k == 3) check_val({tag, "_je_valE"}, valE, 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; icode = 4'h1; ifunc = 4'h0; valC = '0; valA = '0; valB = '0;

    exec("irmovq_rst", 1'b1, 4'h3, 4'h0, 64'd100, 64'd0, 64'd0, 64'd100, 1'b0);
    probe_cc("reset", 3'b100);
    exec("pushq", 1'b0, 4'hA, 4'h0, 64'd0, 64'd0, 64'd208, 64'd200, 1'b0);
    exec("call", 1'b0, 4'h8, 4'h0, 64'd0, 64'd0, 64'h100, 64'hF8, 1'b0);
    exec("ret", 1'b0, 4'h9, 4'h0, 64'd0, 64'd0, 64'hF8, 64'h100, 1'b0);
    exec("popq", 1'b0, 4'hB, 4'h0, 64'd0, 64'd0, 64'h100, 64'h108, 1'b0);
    exec("rmmovq", 1'b0, 4'h4, 4'h0, 64'd8, 64'd0, 64'h100, 64'h108, 1'b0);
    exec("mrmovq", 1'b0, 4'h5, 4'h0, 64'h10, 64'h5, 64'h20, 64'h30, 1'b0);
    exec("halt", 1'b0, 4'h0, 4'h0, 64'd99, 64'd55, 64'd77, 64'd0, 1'b0);
    exec("badicode", 1'b0, 4'hC, 4'h0, 64'd99, 64'd55, 64'd77, 64'd0, 1'b0);
    exec("jmp", 1'b0, 4'h7, 4'h0, 64'd99, 64'd55, 64'd77, 64'd0, 1'b1);
    exec("rrmovq", 1'b0, 4'h2, 4'h0, 64'd0, 64'd20, 64'd40, 64'd20, 1'b1);
    exec("cmovne_zf", 1'b0, 4'h2, 4'h4, 64'd0, 64'd60, 64'd0, 64'd60, 1'b0);
    probe_cc("after_moves", 3'b100);

    exec("addq", 1'b0, 4'h6, 4'h0, 64'd0, 64'd200, 64'd100, 64'd300, 1'b0);
    probe_cc("addq", 3'b000);
    exec("subq_zero", 1'b0, 4'h6, 4'h1, 64'd0, 64'd200, 64'd200, 64'd0, 1'b0);
    probe_cc("subq_zero", 3'b100);
    exec("subq_neg", 1'b0, 4'h6, 4'h1, 64'd0, 64'd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    probe_cc("subq_neg", 3'b010);
    exec("addq_ovf", 1'b0, 4'h6, 4'h0, 64'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
         64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    probe_cc("addq_ovf", 3'b011);
    exec("subq_ovf", 1'b0, 4'h6, 4'h1, 64'd0, 64'd1, 64'h8000_0000_0000_0000,
         64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    probe_cc("subq_ovf", 3'b001);
    exec("andq", 1'b0, 4'h6, 4'h2, 64'd0, 64'hF0, 64'h0F, 64'd0, 1'b0);
    probe_cc("andq", 3'b100);
    exec("opq_bad", 1'b0, 4'h6, 4'h7, 64'd0, 64'd5, 64'd5, 64'd0, 1'b0);
    probe_cc("opq_bad", 3'b100);
    exec("xorq", 1'b0, 4'h6, 4'h3, 64'd0, 64'hFF, 64'h0F, 64'hF0, 1'b0);
    probe_cc("xorq", 3'b000);
    exec("jxx_f9", 1'b0, 4'h7, 4'h9, 64'd1, 64'd2, 64'd3, 64'd0, 1'b0);
    exec("cmov_f9", 1'b0, 4'h2, 4'h9, 64'd1, 64'd7, 64'd3, 64'd7, 1'b0);
    exec("cmovg", 1'b0, 4'h2, 4'h6, 64'd0, 64'd9, 64'd3, 64'd9, 1'b1);

    exec("rst_prio", 1'b1, 4'h6, 4'h0, 64'd0, 64'd1, 64'd2, 64'd3, 1'b0);
    probe_cc("rst_prio", 3'b100);
    exec("post_rst_sub", 1'b0, 4'h6, 4'h1, 64'd0, 64'd3, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    probe_cc("post_rst_sub", 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
